mem_access_ctrl: RTL

- MEM-stage load/store controller of the 5-stage MIPS pipeline; sits between EX/MEM and MEM/WB.
- Runs a req/ack handshake to data memory and stalls the pipeline while an access is outstanding.
- Aligns load/store data (big-endian) and implements LL/SC semantics.
- Produces the LLbit write request (we/value) for the LL-bit register, which it consumes back through LLbit_i with a WB-stage bypass.

---
 rtl/mem_access_ctrl.sv | 242 ++++++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_ctrl.sv
// MEM-stage load/store controller for the 5-stage MIPS pipeline.
// Drives a req/ack data-memory handshake, stalls the pipeline while an
// access is outstanding, aligns big-endian load/store data and handles
// the LL/SC reservation bit.
module mem_access_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic [3:0]  op_i,
  input  logic [31:0] mem_addr_i,
  input  logic [31:0] reg2_i,
  input  logic [4:0]  wd_i,
  input  logic        wreg_i,
  input  logic [31:0] wdata_i,
  input  logic        LLbit_i,
  input  logic        wb_LLbit_we_i,
  input  logic        wb_LLbit_value_i,
  input  logic [31:0] d_rdata_i,
  input  logic        d_ack_i,
  output logic        d_req_o,
  output logic        d_we_o,
  output logic [31:0] d_addr_o,
  output logic [3:0]  d_sel_o,
  output logic [31:0] d_wdata_o,
  output logic [4:0]  wd_o,
  output logic        wreg_o,
  output logic [31:0] wdata_o,
  output logic        LLbit_we_o,
  output logic        LLbit_value_o,
  output logic        stall_req_o,
  output logic        excp_align_o
);

  localparam logic [3:0] OP_NOP = 4'd0;
  localparam logic [3:0] OP_LB  = 4'd1;
  localparam logic [3:0] OP_LBU = 4'd2;
  localparam logic [3:0] OP_LH  = 4'd3;
  localparam logic [3:0] OP_LHU = 4'd4;
  localparam logic [3:0] OP_LW  = 4'd5;
  localparam logic [3:0] OP_SB  = 4'd6;
  localparam logic [3:0] OP_SH  = 4'd7;
  localparam logic [3:0] OP_SW  = 4'd8;
  localparam logic [3:0] OP_LL  = 4'd9;
  localparam logic [3:0] OP_SC  = 4'd10;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Byte-lane enables for an access; bit 3 is the most significant byte.
  function automatic logic [3:0] lane_sel(input logic [3:0] op, input logic [1:0] off);
    logic [3:0] sel;
    case (op)
      OP_LB, OP_LBU, OP_SB: begin
        case (off)
          2'b00:   sel = 4'b1000;
          2'b01:   sel = 4'b0100;
          2'b10:   sel = 4'b0010;
          2'b11:   sel = 4'b0001;
          default: sel = 4'b0000;
        endcase
      end
      OP_LH, OP_LHU, OP_SH: sel = off[1] ? 4'b0011 : 4'b1100;
      default:              sel = 4'b1111;
    endcase
    return sel;
  endfunction

  // Store data replicated across the word so any selected lane carries it.
  function automatic logic [31:0] store_data(input logic [3:0] op, input logic [31:0] reg2);
    logic [31:0] d;
    case (op)
      OP_SB:   d = {4{reg2[7:0]}};
      OP_SH:   d = {2{reg2[15:0]}};
      default: d = reg2;
    endcase
    return d;
  endfunction

  // Extract and extend the addressed byte/half from the captured bus word.
  function automatic logic [31:0] load_data(input logic [3:0] op, input logic [1:0] off,
                                            input logic [31:0] word);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] d;
    case (off)
      2'b00:   b = word[31:24];
      2'b01:   b = word[23:16];
      2'b10:   b = word[15:8];
      2'b11:   b = word[7:0];
      default: b = 8'h00;
    endcase
    h = off[1] ? word[15:0] : word[31:16];
    case (op)
      OP_LB:   d = {{24{b[7]}}, b};
      OP_LBU:  d = {24'h000000, b};
      OP_LH:   d = {{16{h[15]}}, h};
      OP_LHU:  d = {16'h0000, h};
      default: d = word;
    endcase
    return d;
  endfunction

  function automatic logic is_load(input logic [3:0] op);
    logic r;
    case (op)
      OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL: r = 1'b1;
      default:                                    r = 1'b0;
    endcase
    return r;
  endfunction

  function automatic logic is_store(input logic [3:0] op);
    logic r;
    case (op)
      OP_SB, OP_SH, OP_SW, OP_SC: r = 1'b1;
      default:                    r = 1'b0;
    endcase
    return r;
  endfunction

  state_e      state_r;
  state_e      next_state_s;
  logic [31:0] rdata_r;
  logic [3:0]  op_r;
  logic [1:0]  off_r;
  logic        llbit_eff_s;
  logic        misalign_s;
  logic        sc_fail_s;
  logic        start_s;

  // Decode the incoming op: alignment, SC outcome and whether a bus access starts.
  always_comb begin
    llbit_eff_s = wb_LLbit_we_i ? wb_LLbit_value_i : LLbit_i;
    misalign_s  = 1'b0;
    case (op_i)
      OP_LH, OP_LHU, OP_SH:       misalign_s = mem_addr_i[0];
      OP_LW, OP_SW, OP_LL, OP_SC: misalign_s = (mem_addr_i[1:0] != 2'b00);
      default:                    misalign_s = 1'b0;
    endcase
    sc_fail_s = (op_i == OP_SC) && !misalign_s && !llbit_eff_s;
    start_s   = (is_load(op_i) || is_store(op_i)) && !misalign_s && !sc_fail_s;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic; flush always returns to IDLE.
  always_comb begin
    next_state_s = state_r;
    if (flush) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: next_state_s = start_s ? ST_BUSY : ST_IDLE;
        ST_BUSY: next_state_s = d_ack_i ? ST_DONE : ST_BUSY;
        ST_DONE: next_state_s = ST_IDLE;
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // Bus request registers, read-data capture and the latched op/offset of the access.
  always_ff @(posedge clk) begin
    if (rst) begin
      d_req_o   <= 1'b0;
      d_we_o    <= 1'b0;
      d_addr_o  <= 32'h0000_0000;
      d_sel_o   <= 4'b0000;
      d_wdata_o <= 32'h0000_0000;
      rdata_r   <= 32'h0000_0000;
      op_r      <= OP_NOP;
      off_r     <= 2'b00;
    end else if (flush) begin
      d_req_o <= 1'b0;
      d_we_o  <= 1'b0;
    end else if ((state_r == ST_IDLE) && start_s) begin
      d_req_o   <= 1'b1;
      d_we_o    <= is_store(op_i);
      d_addr_o  <= {mem_addr_i[31:2], 2'b00};
      d_sel_o   <= lane_sel(op_i, mem_addr_i[1:0]);
      d_wdata_o <= store_data(op_i, reg2_i);
      op_r      <= op_i;
      off_r     <= mem_addr_i[1:0];
    end else if ((state_r == ST_BUSY) && d_ack_i) begin
      rdata_r <= d_rdata_i;
      d_req_o <= 1'b0;
      d_we_o  <= 1'b0;
    end
  end

  // Result, LL-bit and stall outputs towards MEM/WB and the hazard unit.
  always_comb begin
    wd_o          = wd_i;
    wreg_o        = wreg_i;
    wdata_o       = wdata_i;
    LLbit_we_o    = 1'b0;
    LLbit_value_o = 1'b0;
    stall_req_o   = 1'b0;
    excp_align_o  = misalign_s;
    if (flush) begin
      wreg_o = 1'b0;
    end else if (state_r == ST_BUSY) begin
      wreg_o      = 1'b0;
      stall_req_o = 1'b1;
    end else if (state_r == ST_DONE) begin
      if (is_load(op_r)) begin
        wdata_o = load_data(op_r, off_r, rdata_r);
        if (op_r == OP_LL) begin
          LLbit_we_o    = 1'b1;
          LLbit_value_o = 1'b1;
        end else begin
          LLbit_we_o = 1'b0;
        end
      end else if (op_r == OP_SC) begin
        wdata_o       = 32'h0000_0001;
        LLbit_we_o    = 1'b1;
        LLbit_value_o = 1'b0;
      end else begin
        wreg_o = 1'b0;
      end
    end else if (misalign_s) begin
      wreg_o = 1'b0;
    end else if (sc_fail_s) begin
      wdata_o = 32'h0000_0000;
    end else if (start_s) begin
      wreg_o      = 1'b0;
      stall_req_o = 1'b1;
    end else begin
      wreg_o = wreg_i;
    end
  end

endmodule
